// File: rtl/ring_token_arbiter.sv
`default_nettype none
// ring_token_arbiter: round-robin arbiter with a one-hot rotating token,
// registered one-hot grants and a hold limit that forces release.
module ring_token_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    localparam int IDW     = (N > 1) ? $clog2(N) : 1,
    localparam int CW      = $clog2(MAX_HOLD + 1)
) (
    input  logic           CLK,
    input  logic           CLR,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic [N-1:0]   token,
    output logic           timeout
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   token_q, token_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [CW-1:0]  hold_q, hold_d;
    logic           timeout_q, timeout_d;

    int             tok_idx;
    logic           win_found;
    logic [IDW-1:0] win_idx;

    always_comb begin
        tok_idx = 0;
        for (int i = 0; i < N; i++) begin
            if (token_q[i]) tok_idx = i;
        end
    end

    // Circular search starting at the token position, wrapping N-1 -> 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!win_found && req[(tok_idx + k) % N]) begin
                win_found = 1'b1;
                win_idx   = IDW'((tok_idx + k) % N);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        token_d   = token_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (win_found) begin
                    gnt_d   = {{(N-1){1'b0}}, 1'b1} << win_idx;
                    owner_d = win_idx;
                    hold_d  = CW'(1);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!req[owner_q] || (hold_q == CW'(MAX_HOLD))) begin
                    // Token moves one past the owner: rotate the grant left by one.
                    gnt_d     = '0;
                    token_d   = {gnt_q[N-2:0], gnt_q[N-1]};
                    state_d   = IDLE;
                    timeout_d = req[owner_q];
                end else begin
                    hold_d = hold_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q   <= IDLE;
            token_q   <= {{(N-1){1'b0}}, 1'b1};
            gnt_q     <= '0;
            owner_q   <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            token_q   <= token_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        gnt_id = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_q[i]) gnt_id = gnt_id | IDW'(i);
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = |gnt_q;
    assign token     = token_q;
    assign timeout   = timeout_q;

endmodule
`default_nettype wire
